// File: rtl/clock_ctrl_pkg.sv
// Shared encodings for the clock mode controller: modes, display sources, button indices.
package clock_ctrl_pkg;

    typedef enum logic [2:0] {
        MODE_RUN       = 3'd0,
        MODE_SET_TIME  = 3'd1,
        MODE_SET_DATE  = 3'd2,
        MODE_SET_ALARM = 3'd3,
        MODE_STOPWATCH = 3'd4
    } mode_e;

    typedef enum logic [1:0] {
        DISP_TIME  = 2'd0,
        DISP_DATE  = 2'd1,
        DISP_ALARM = 2'd2,
        DISP_SW    = 2'd3
    } disp_e;

    localparam int BTN_MODE = 0;
    localparam int BTN_SEL  = 1;
    localparam int BTN_INC  = 2;
    localparam int BTN_DEC  = 3;

    function automatic logic is_set_mode(mode_e m);
        return (m == MODE_SET_TIME) || (m == MODE_SET_DATE) || (m == MODE_SET_ALARM);
    endfunction

    function automatic disp_e disp_of(mode_e m);
        case (m)
            MODE_SET_DATE:  return DISP_DATE;
            MODE_SET_ALARM: return DISP_ALARM;
            MODE_STOPWATCH: return DISP_SW;
            default:        return DISP_TIME;
        endcase
    endfunction

endpackage

// File: rtl/clock_mode_ctrl_if.sv
// Button/command bundle between the mode controller (ctrl) and its consumers (disp).
interface clock_mode_ctrl_if;
    logic       enb;
    logic [3:0] btn;
    logic       sw2;
    logic [2:0] mode;
    logic       field;
    logic       inc_pulse;
    logic       dec_pulse;
    logic       sw_startstop;
    logic       sw_clear;
    logic [1:0] disp_sel;
    logic       blank_hi;
    logic       blank_lo;

    modport ctrl (
        input  enb, btn, sw2,
        output mode, field, inc_pulse, dec_pulse, sw_startstop, sw_clear,
               disp_sel, blank_hi, blank_lo
    );

    modport disp (
        output enb, btn, sw2,
        input  mode, field, inc_pulse, dec_pulse, sw_startstop, sw_clear,
               disp_sel, blank_hi, blank_lo
    );
endinterface

// File: rtl/btn_debounce.sv
// Purpose: synchronise and debounce one raw button, emit a one-cycle pulse per accepted press.
// Latency: level flips 1+DEBOUNCE_CYC edges after first sample; rise follows one edge later.
// Backpressure: none; free-running conditioner.
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise
);
    localparam int CW = (DEBOUNCE_CYC < 2) ? 1 : $clog2(DEBOUNCE_CYC + 1);

    logic          sync1, sync2;
    logic [CW-1:0] cnt;
    logic          level_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            cnt     <= '0;
            level   <= 1'b0;
            level_d <= 1'b0;
            rise    <= 1'b0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_d <= level;
            rise    <= level & ~level_d;
            // Counter tracks consecutive disagreement; any agreeing cycle restarts it.
            if (sync2 != level) begin
                if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
                    level <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

// File: rtl/clock_mode_ctrl.sv
// Mode/field FSM for the digital clock; debounces 4 buttons and emits adjust/stopwatch pulses.
// Latency: press action registered 3+DEBOUNCE_CYC edges after first sample; sw2 acts after 2-FF sync.
// Backpressure: none; presses arbitrated mode>sel>inc>dec, losers dropped. SET_TIMEOUT_EN adds auto-exit.
module clock_mode_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 20,
    parameter int TIMEOUT_S    = 30
) (
    input  logic               clk,
    input  logic               rst_n,
    clock_mode_ctrl_if.ctrl    bus
);
    logic [3:0] press;
    logic [3:0] level;
    logic [3:0] win;
    logic       sw2_m, sw2_s;

    mode_e mode_q, mode_n;
    logic  field_q, field_n;
    logic  blink_q, blink_n;
    logic  inc_q, inc_n, dec_q, dec_n, ss_q, ss_n, clr_q, clr_n;
    disp_e disp_q;
    logic  bhi_q, blo_q;

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (bus.btn[i]),
            .level (level[i]),
            .rise  (press[i])
        );
    end

`ifdef SET_TIMEOUT_EN
    localparam int TW = (TIMEOUT_S < 2) ? 1 : $clog2(TIMEOUT_S + 1);
    logic [TW-1:0] tcnt_q, tcnt_n;
`endif

    always_comb begin
        win = 4'b0000;
        if      (press[BTN_MODE]) win[BTN_MODE] = 1'b1;
        else if (press[BTN_SEL])  win[BTN_SEL]  = 1'b1;
        else if (press[BTN_INC])  win[BTN_INC]  = 1'b1;
        else if (press[BTN_DEC])  win[BTN_DEC]  = 1'b1;
    end

    always_comb begin
        mode_n  = mode_q;
        field_n = field_q;
        blink_n = blink_q;
        inc_n   = 1'b0;
        dec_n   = 1'b0;
        ss_n    = 1'b0;
        clr_n   = 1'b0;
        case (mode_q)
            MODE_RUN: begin
                if (sw2_s)              mode_n = MODE_STOPWATCH;
                else if (win[BTN_MODE]) mode_n = MODE_SET_TIME;
            end
            MODE_SET_TIME, MODE_SET_DATE, MODE_SET_ALARM: begin
                if (win[BTN_MODE]) begin
                    case (mode_q)
                        MODE_SET_TIME: mode_n = MODE_SET_DATE;
                        MODE_SET_DATE: mode_n = MODE_SET_ALARM;
                        default:       mode_n = MODE_RUN;
                    endcase
                end
                if (win[BTN_SEL]) field_n = ~field_q;
                inc_n = win[BTN_INC];
                dec_n = win[BTN_DEC];
                if (bus.enb) blink_n = ~blink_q;
            end
            MODE_STOPWATCH: begin
                if (!sw2_s) begin
                    mode_n = MODE_RUN;
                end else begin
                    ss_n  = win[BTN_INC];
                    clr_n = win[BTN_DEC];
                end
            end
            default: mode_n = MODE_RUN;
        endcase
`ifdef SET_TIMEOUT_EN
        tcnt_n = tcnt_q;
        if (is_set_mode(mode_q)) begin
            // Timeout takes precedence over anything pressed in the same cycle.
            if (bus.enb && tcnt_q == TW'(TIMEOUT_S - 1)) begin
                mode_n  = MODE_RUN;
                field_n = 1'b0;
                inc_n   = 1'b0;
                dec_n   = 1'b0;
            end else if (win != 4'b0000) begin
                tcnt_n = '0;
            end else if (bus.enb) begin
                tcnt_n = tcnt_q + TW'(1);
            end
        end else begin
            tcnt_n = '0;
        end
        if (mode_n != mode_q) tcnt_n = '0;
`endif
        if (mode_n != mode_q) begin
            field_n = 1'b0;
            blink_n = 1'b0;
        end else if (field_n != field_q) begin
            blink_n = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw2_m   <= 1'b0;
            sw2_s   <= 1'b0;
            mode_q  <= MODE_RUN;
            field_q <= 1'b0;
            blink_q <= 1'b0;
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
            ss_q    <= 1'b0;
            clr_q   <= 1'b0;
            disp_q  <= DISP_TIME;
            bhi_q   <= 1'b0;
            blo_q   <= 1'b0;
        end else begin
            sw2_m   <= bus.sw2;
            sw2_s   <= sw2_m;
            mode_q  <= mode_n;
            field_q <= field_n;
            blink_q <= blink_n;
            inc_q   <= inc_n;
            dec_q   <= dec_n;
            ss_q    <= ss_n;
            clr_q   <= clr_n;
            disp_q  <= disp_of(mode_n);
            bhi_q   <= is_set_mode(mode_n) & ~field_n & blink_n;
            blo_q   <= is_set_mode(mode_n) &  field_n & blink_n;
        end
    end

`ifdef SET_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tcnt_q <= '0;
        else        tcnt_q <= tcnt_n;
    end
`endif

    assign bus.mode         = mode_q;
    assign bus.field        = field_q;
    assign bus.inc_pulse    = inc_q;
    assign bus.dec_pulse    = dec_q;
    assign bus.sw_startstop = ss_q;
    assign bus.sw_clear     = clr_q;
    assign bus.disp_sel     = disp_q;
    assign bus.blank_hi     = bhi_q;
    assign bus.blank_lo     = blo_q;
endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed bench for clock_mode_ctrl with DEBOUNCE_CYC=4 (TIMEOUT_S=3 when SET_TIMEOUT_EN is defined).
module tb_clock_mode_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   inc_cnt = 0, dec_cnt = 0, ss_cnt = 0, clr_cnt = 0, both_cnt = 0;
    int   i0, d0, s0, c0;

    clock_mode_ctrl_if bus();

    clock_mode_ctrl #(.DEBOUNCE_CYC(4), .TIMEOUT_S(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        inc_cnt  <= inc_cnt + int'(bus.inc_pulse);
        dec_cnt  <= dec_cnt + int'(bus.dec_pulse);
        ss_cnt   <= ss_cnt + int'(bus.sw_startstop);
        clr_cnt  <= clr_cnt + int'(bus.sw_clear);
        both_cnt <= both_cnt + int'(bus.inc_pulse & bus.dec_pulse);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic press(input int idx);
        bus.btn[idx] = 1'b1;
        repeat (10) tick();
        bus.btn[idx] = 1'b0;
        repeat (10) tick();
    endtask

    task automatic pulse_enb();
        bus.enb = 1'b1;
        tick();
        bus.enb = 1'b0;
    endtask

    initial begin
        bus.enb = 1'b0;
        bus.btn = 4'b0000;
        bus.sw2 = 1'b0;
        repeat (3) tick();
        check("rst_mode", bus.mode, 0);
        check("rst_field", bus.field, 0);
        check("rst_disp", bus.disp_sel, 0);
        check("rst_pulses", {bus.inc_pulse, bus.dec_pulse, bus.sw_startstop, bus.sw_clear}, 0);
        check("rst_blank", {bus.blank_hi, bus.blank_lo}, 0);
        rst_n = 1'b1;
        tick();

        // first sample at the next edge N; action must land exactly at N+7
        bus.btn[0] = 1'b1;
        repeat (7) tick();
        check("lat_before", bus.mode, 0);
        tick();
        check("lat_at", bus.mode, 1);
        check("lat_disp", bus.disp_sel, 0);
        repeat (2) tick();
        bus.btn[0] = 1'b0;
        repeat (10) tick();
        check("held_no_repeat", bus.mode, 1);

        press(0);
        check("step_date", bus.mode, 2);
        check("disp_date", bus.disp_sel, 1);
        press(0);
        check("step_alarm", bus.mode, 3);
        check("disp_alarm", bus.disp_sel, 2);
        press(0);
        check("step_run", bus.mode, 0);
        check("disp_run", bus.disp_sel, 0);
        press(0);
        check("reenter_time", bus.mode, 1);

        // bounce: 2-cycle runs never reach the 4-cycle debounce threshold
        i0 = inc_cnt;
        for (int k = 0; k < 10; k++) begin
            bus.btn[2] = (k % 2 == 0);
            repeat (2) tick();
        end
        check("bounce_none", inc_cnt, i0);
        bus.btn[2] = 1'b1;
        repeat (20) tick();
        check("bounce_one", inc_cnt, i0 + 1);
        bus.btn[2] = 1'b0;
        repeat (10) tick();
        check("bounce_norepeat", inc_cnt, i0 + 1);
        check("bounce_nodec", dec_cnt, 0);

        press(0);
        check("sim_mode", bus.mode, 2);
        check("sim_field0", bus.field, 0);
        i0 = inc_cnt;
        d0 = dec_cnt;
        bus.btn = 4'b0110;
        repeat (10) tick();
        bus.btn = 4'b0000;
        repeat (10) tick();
        check("sim_sel_wins", bus.field, 1);
        check("sim_sel_noinc", inc_cnt, i0);
        bus.btn = 4'b1100;
        repeat (10) tick();
        bus.btn = 4'b0000;
        repeat (10) tick();
        check("sim_inc_wins", inc_cnt, i0 + 1);
        check("sim_inc_nodec", dec_cnt, d0);

        press(0);
        check("alarm_mode", bus.mode, 3);
        check("alarm_field_clr", bus.field, 0);
        press(1);
        check("alarm_field1", bus.field, 1);
        pulse_enb();
        check("blink1_lo", bus.blank_lo, 1);
        check("blink1_hi", bus.blank_hi, 0);
        tick();
        pulse_enb();
        check("blink2_lo", bus.blank_lo, 0);
        press(2);
        pulse_enb();
        check("blink3_lo", bus.blank_lo, 1);
        check("blink3_hi", bus.blank_hi, 0);
        tick();
        pulse_enb();
        check("blink4_lo", bus.blank_lo, 0);
        press(2);
        pulse_enb();
        check("blink5_lo", bus.blank_lo, 1);
        press(1);
        check("blink_sel_field", bus.field, 0);
        check("blink_sel_hi", bus.blank_hi, 0);
        check("blink_sel_lo", bus.blank_lo, 0);
        check("alarm_still", bus.mode, 3);

        press(0);
        check("back_run", bus.mode, 0);
        bus.sw2 = 1'b1;
        repeat (2) tick();
        check("sw_sync_wait", bus.mode, 0);
        tick();
        check("sw_enter", bus.mode, 4);
        check("sw_disp", bus.disp_sel, 3);
        i0 = inc_cnt;
        s0 = ss_cnt;
        c0 = clr_cnt;
        press(2);
        check("sw_startstop", ss_cnt, s0 + 1);
        check("sw_noinc", inc_cnt, i0);
        press(3);
        check("sw_clear", clr_cnt, c0 + 1);
        check("sw_ss_once", ss_cnt, s0 + 1);
        press(0);
        check("sw_ignore_mode", bus.mode, 4);
        bus.sw2 = 1'b0;
        repeat (2) tick();
        check("sw_exit_wait", bus.mode, 4);
        tick();
        check("sw_exit", bus.mode, 0);
        check("sw_exit_disp", bus.disp_sel, 0);

        // reset while a button is held: the held button counts as a fresh press
        bus.btn[0] = 1'b1;
        repeat (10) tick();
        check("pre_reset_mode", bus.mode, 1);
        rst_n = 1'b0;
        #1;
        check("async_reset", bus.mode, 0);
        tick();
        rst_n = 1'b1;
        repeat (7) tick();
        check("held_fresh_wait", bus.mode, 0);
        tick();
        check("held_fresh", bus.mode, 1);
        bus.btn[0] = 1'b0;
        repeat (10) tick();

`ifdef SET_TIMEOUT_EN
        pulse_enb();
        tick();
        pulse_enb();
        tick();
        check("to_before", bus.mode, 1);
        pulse_enb();
        check("to_fire", bus.mode, 0);
        check("to_field", bus.field, 0);
        press(0);
        check("to_reenter", bus.mode, 1);
        pulse_enb();
        tick();
        pulse_enb();
        press(2);
        pulse_enb();
        check("to_press_clears", bus.mode, 1);
`else
        repeat (5) begin
            pulse_enb();
            tick();
        end
        check("no_timeout", bus.mode, 1);
`endif
        check("never_inc_dec", both_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
